// File: rtl/frame_writer_pkg.sv
// Shared layout constants, colour codes and FSM state type for the paint
// frame buffer. The display pixel generator uses the same layout constants
// so that both memory ports agree on the pixel packing.
//
// Layout: 4 pixels per 16-bit word, pixel at x[1:0]=n in bits [4n+3:4n],
// nibble format {1'b0, R, G, B}. The draw area starts at row PALETTE_H.
package frame_writer_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int PALETTE_H = 80;
    localparam int BOX1_X    = 213;    // last column of the red box
    localparam int BOX2_X    = 426;    // last column of the green box
    localparam int WORDS     = 64000;  // (V_RES - PALETTE_H) * H_RES / 4

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WT,
        ST_WR,
        ST_CLR
    } fw_state_t;

    // Replace one pixel nibble of a memory word, keeping the other three.
    function automatic logic [15:0] merge_nibble(input logic [15:0] word,
                                                 input logic [1:0]  idx,
                                                 input logic [3:0]  nib);
        logic [15:0] r;
        r = word;
        r[idx*4 +: 4] = nib;
        return r;
    endfunction

endpackage

// File: rtl/frame_writer_pixel_addr.sv
// pixel_addr: combinational mapping of a screen coordinate to its location
// in the frame buffer. Usable by both the write side and the display side.
//
// Ports:
//   x, y        screen column / row
//   word_addr   word holding the pixel (valid only when in_draw_area)
//   nibble      nibble index inside the word
//   in_draw_area  1 when the coordinate lies inside the draw area
module pixel_addr
    import frame_writer_pkg::*;
#(
    parameter int H_RES     = frame_writer_pkg::H_RES,
    parameter int V_RES     = frame_writer_pkg::V_RES,
    parameter int PALETTE_H = frame_writer_pkg::PALETTE_H,
    parameter int ADDR_W    = 16
) (
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    output logic [ADDR_W-1:0] word_addr,
    output logic [1:0]        nibble,
    output logic              in_draw_area
);
    logic [10:0] dy;
    logic [17:0] p;

    assign dy = y - 11'(PALETTE_H);
    // (y-80)*640 + x as two shifts and adds; fits 18 bits inside the draw area.
    assign p = 18'({dy, 9'b0}) + 18'({dy, 7'b0}) + 18'(x);

    assign word_addr    = ADDR_W'(p[17:2]);
    assign nibble       = p[1:0];
    assign in_draw_area = (y >= 11'(PALETTE_H)) && (y < 11'(V_RES)) && (x < 11'(H_RES));

endmodule

// File: rtl/frame_writer.sv
// frame_writer: write-side controller of the paint frame buffer. Turns the
// mouse position and button into read-modify-write pixel updates, selects
// the paint colour from the palette band, and clears the draw area.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   x, y, paint       mouse column, row, left button level
//   clear_req         one-cycle pulse: zero the whole draw area
//   mem_rdata         memory read data, valid one cycle after mem_addr
//   mem_addr/wdata/we registered memory write-port controls
//   busy              high whenever the FSM is not idle
//   color             current paint colour {R,G,B}
//   dbg_state         current FSM state
//
// Handshake: inputs are only looked at in IDLE; a paint is a fixed 4-cycle
// transaction (RD, WT, WR, back to IDLE) and a clear is one word per cycle.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int H_RES     = frame_writer_pkg::H_RES,
    parameter int V_RES     = frame_writer_pkg::V_RES,
    parameter int PALETTE_H = frame_writer_pkg::PALETTE_H,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    input  logic              paint,
    input  logic              clear_req,
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic [2:0]        color,
    output fw_state_t         dbg_state
);
    localparam logic [ADDR_W-1:0] LAST_WORD =
        ADDR_W'((H_RES * (V_RES - PALETTE_H)) / 4 - 1);

    fw_state_t         state, next_state;
    logic [ADDR_W-1:0] pix_word;
    logic [1:0]        pix_nib;
    logic              pix_in_draw;
    logic              paint_go, pal_click;
    logic [2:0]        band_color;

    // Latched paint target, held across RD/WT.
    logic [1:0]        nib_q;
    logic [3:0]        pix_q;

    // Next values of the registered outputs / latches.
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       wdata_d;
    logic              we_d;
    logic [2:0]        color_d;
    logic [1:0]        nib_d;
    logic [3:0]        pix_d;

    pixel_addr #(
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .PALETTE_H (PALETTE_H),
        .ADDR_W    (ADDR_W)
    ) u_pixel_addr (
        .x            (x),
        .y            (y),
        .word_addr    (pix_word),
        .nibble       (pix_nib),
        .in_draw_area (pix_in_draw)
    );

    assign paint_go  = paint && pix_in_draw;
    // The palette band spans the full row width; any x selects a box.
    assign pal_click = paint && (y < 11'(PALETTE_H));
    assign band_color = (x <= 11'(BOX1_X)) ? RED :
                        (x <= 11'(BOX2_X)) ? GREEN : BLUE;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (clear_req)     next_state = ST_CLR;
                else if (paint_go) next_state = ST_RD;
            end
            ST_RD:   next_state = ST_WT;
            ST_WT:   next_state = ST_WR;
            ST_WR:   next_state = ST_IDLE;
            ST_CLR:  if (mem_addr == LAST_WORD) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered memory port and latches.
    always_comb begin
        busy    = (state != ST_IDLE);
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        we_d    = 1'b0;
        color_d = color;
        nib_d   = nib_q;
        pix_d   = pix_q;
        unique case (state)
            ST_IDLE: begin
                if (clear_req) begin
                    addr_d  = '0;
                    wdata_d = '0;
                    we_d    = 1'b1;
                end else if (paint_go) begin
                    addr_d = pix_word;
                    nib_d  = pix_nib;
                    pix_d  = {1'b0, color};
                end else if (pal_click) begin
                    color_d = band_color;
                end
            end
            ST_WT: begin
                wdata_d = merge_nibble(mem_rdata, nib_q, pix_q);
                we_d    = 1'b1;
            end
            ST_CLR: begin
                // Last word is being written this cycle; stop after it.
                if (mem_addr != LAST_WORD) begin
                    addr_d = mem_addr + 1'b1;
                    we_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            color     <= WHITE;
            nib_q     <= '0;
            pix_q     <= '0;
        end else begin
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_we    <= we_d;
            color     <= color_d;
            nib_q     <= nib_d;
            pix_q     <= pix_d;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_frame_writer.sv
module tb_frame_writer;
    import frame_writer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic        paint = 1'b0;
    logic        clear_req = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic [2:0]  color;
    fw_state_t   dbg_state;

    int checks = 0;
    int failures = 0;

    // Scoreboard: expected writes as {addr, data}
    logic [31:0] exp_q[$];

    // Reference model: one entry per pixel, plus the current colour
    logic [3:0]  ref_pix [0:255999];
    logic [2:0]  color_m = WHITE;

    // Memory model: 1-cycle synchronous read, write on mem_we
    logic [15:0] mem [0:63999];

    frame_writer dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .paint     (paint),
        .clear_req (clear_req),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .color     (color),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (int'(mem_addr) < 64000) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end else begin
            mem_rdata <= 16'h0000;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pack_word(input int w);
        return {ref_pix[4*w+3], ref_pix[4*w+2], ref_pix[4*w+1], ref_pix[4*w]};
    endfunction

    // Monitor: every write the DUT performs must match the next expectation
    always @(negedge clk) begin
        logic [31:0] e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h expected=none", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(mem_addr), 32'(e[31:16]));
                chk("write_data", 32'(mem_wdata), 32'(e[15:0]));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"},    32'(mem_we), 32'd0);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_color"}, 32'(color), 32'(WHITE));
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // One button press of one cycle at (px, py); classified by the model.
    task automatic do_paint(input int px, input int py);
        int p, w;
        @(negedge clk);
        x = 11'(px); y = 11'(py); paint = 1'b1;
        @(negedge clk);                   // first cycle after acceptance edge
        paint = 1'b0;
        if (py < 80) begin
            color_m = (px <= 213) ? RED : (px <= 426) ? GREEN : BLUE;
            chk("palette_color", 32'(color), 32'(color_m));
            chk("palette_busy", 32'(busy), 32'd0);
        end else if (py < 480 && px < 640) begin
            p = (py - 80) * 640 + px;
            w = p / 4;
            ref_pix[p] = {1'b0, color_m};
            exp_q.push_back({16'(w), pack_word(w)});
            chk("rd_addr", 32'(mem_addr), 32'(w));
            chk("rd_we", 32'(mem_we), 32'd0);
            chk("rd_busy", 32'(busy), 32'd1);
            @(negedge clk);
            chk("wt_we", 32'(mem_we), 32'd0);
            @(negedge clk);
            chk("wr_we", 32'(mem_we), 32'd1);
            @(negedge clk);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_we", 32'(mem_we), 32'd0);
        end else begin
            chk("oob_busy", 32'(busy), 32'd0);
            chk("oob_we", 32'(mem_we), 32'd0);
        end
    endtask

    task automatic preset_word(input int w, input logic [15:0] v);
        mem[w] <= v;
        for (int n = 0; n < 4; n++) ref_pix[4*w+n] = v[4*n +: 4];
    endtask

    task automatic random_ops(input int count);
        int kind;
        for (int i = 0; i < count; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 1)
                do_paint($urandom_range(0, 2047), $urandom_range(0, 79));
            else if (kind == 2)
                do_paint($urandom_range(640, 2047), $urandom_range(80, 2047));
            else if (kind == 3)
                do_paint($urandom_range(0, 639), $urandom_range(480, 2047));
            else if (kind <= 6)
                do_paint($urandom_range(0, 15), $urandom_range(80, 83));
            else
                do_paint($urandom_range(0, 639), $urandom_range(80, 479));
        end
    endtask

    initial begin
        int n;
        logic [31:0] r;

        for (int w = 0; w < 64000; w++) begin
            r = $urandom;
            mem[w] <= r[15:0];
            for (int k = 0; k < 4; k++) ref_pix[4*w+k] = r[4*k +: 4];
        end

        // Reset
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        // Palette clicks and directed paints
        do_paint(0, 79);
        chk("red_color", 32'(color), 32'(3'b100));
        do_paint(300, 10);
        preset_word(1, 16'hABCD);
        do_paint(5, 80);                 // expects write of 16'hAB2D at word 1
        do_paint(500, 0);
        chk("blue_color", 32'(color), 32'(3'b001));
        preset_word(63999, 16'h0000);
        do_paint(639, 479);              // expects write of 16'h1000 at word 63999
        do_paint(213, 40);
        do_paint(214, 40);
        do_paint(426, 40);
        do_paint(427, 40);

        random_ops(60);

        // Clear and paint together: clear wins
        for (int w = 0; w < 64000; w++) exp_q.push_back({16'(w), 16'h0000});
        for (int p = 0; p < 256000; p++) ref_pix[p] = 4'h0;
        @(negedge clk);
        clear_req = 1'b1; paint = 1'b1; x = 11'd10; y = 11'd100;
        @(negedge clk);
        clear_req = 1'b0; paint = 1'b0;
        n = 0;
        while (busy && n < 70000) begin
            @(negedge clk);
            n++;
        end
        chk("clear_length", 32'(n), 32'd64000);
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_drained", 32'(exp_q.size()), 32'd0);
        chk("clear_color", 32'(color), 32'(color_m));

        // Reset while waiting for read data
        @(negedge clk);
        x = 11'd20; y = 11'd200; paint = 1'b1;
        @(negedge clk);
        paint = 1'b0;
        @(negedge clk);
        chk("wt_state", 32'(dbg_state), 32'(ST_WT));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        color_m = WHITE;
        check_reset_state("reset_wt");

        // Abandon a clear after 1000 words
        for (int w = 0; w < 1000; w++) begin
            exp_q.push_back({16'(w), 16'h0000});
            for (int k = 0; k < 4; k++) ref_pix[4*w+k] = 4'h0;
        end
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (999) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        color_m = WHITE;
        check_reset_state("reset_clr");
        chk("abort_drained", 32'(exp_q.size()), 32'd0);

        // Out-of-range paints
        do_paint(700, 200);
        do_paint(100, 500);

        random_ops(40);

        repeat (5) @(negedge clk);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
